// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: next-PC select codes, FSM states,
// and the instruction register field positions.
package pc_sequencer_pkg;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_DECODE   = 2'd1,
      ST_WAIT_UPD = 2'd2
   } state_e;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;
   localparam int ADDR_HI   = 25;
   localparam int ADDR_LO   = 0;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and memory.
interface pc_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_timer.sv
// Counts fetch cycles without an acknowledge; expired marks the LIMIT-th one
// and the count restarts from zero on that edge.
module pc_fetch_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   assign expired = enable && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= expired ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch / decode / wait-for-update loop.
// Optional macro PC_ALIGN_CHECK_EN rejects misaligned PC loads with a sticky fault.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pc_sequencer_if.master        bus,
   output logic [31:0]           PC,
   output logic [5:0]            opcode,
   output logic [25:0]           address,
   output logic [15:0]           immediate,
   output logic [4:0]            rs,
   input  logic [31:0]           PC4,
   input  logic [31:0]           branchAddress,
   input  logic [31:0]           jumpAddress,
   input  logic [1:0]            pc_src,
   input  logic                  branch_taken,
   input  logic                  update,
   output logic                  instr_valid,
   output logic                  busy,
   output logic                  timeout,
   output logic                  fault
);

   state_e      state;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] target;
   logic        timeout_q;
   logic        in_fetch;
   logic        expired;
   logic        load_ok;

   assign in_fetch      = (state == ST_FETCH);
   assign bus.imem_req  = in_fetch;
   assign bus.imem_addr = pc_q;
   assign PC            = pc_q;
   assign instr_valid   = (state == ST_DECODE);
   assign busy          = (state != ST_WAIT_UPD);
   assign timeout       = timeout_q;

   assign opcode    = ir_q[OPCODE_HI:OPCODE_LO];
   assign rs        = ir_q[RS_HI:RS_LO];
   assign immediate = ir_q[IMM_HI:IMM_LO];
   assign address   = ir_q[ADDR_HI:ADDR_LO];

   // A not-taken branch falls through to PC4.
   always_comb begin
      target = pc_q;
      unique case (pc_src)
         PC_SRC_PC4:    target = PC4;
         PC_SRC_BRANCH: target = branch_taken ? branchAddress : PC4;
         PC_SRC_JUMP:   target = jumpAddress;
         PC_SRC_HOLD:   target = pc_q;
      endcase
   end

   // An ack on the limit cycle disables the timer, so the fetch wins over the timeout.
   pc_fetch_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
      .clk     (clk),
      .enable  (in_fetch && !bus.imem_ack),
      .clear   (reset || !in_fetch || bus.imem_ack),
      .expired (expired)
   );

`ifdef PC_ALIGN_CHECK_EN
   logic fault_q;

   assign load_ok = !misaligned(target);
   assign fault   = fault_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if (state == ST_WAIT_UPD && update && !load_ok) begin
         fault_q <= 1'b1;
      end
   end
`else
   assign load_ok = 1'b1;
   assign fault   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= expired;
         unique case (state)
            ST_FETCH: begin
               if (bus.imem_ack) begin
                  ir_q  <= bus.imem_rdata;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: state <= ST_WAIT_UPD;
            ST_WAIT_UPD: begin
               if (update && load_ok) begin
                  pc_q  <= target;
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, PC value loaded on reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, maximum FETCH cycles without imem_ack before timeout.
REQ-003 SHALL have ports: clk in 1 (clock); reset in 1 (synchronous, active-high).
REQ-004 SHALL have ports: imem_req out 1; imem_addr out 32; imem_ack in 1; imem_rdata in 32 (instruction fetch handshake).
REQ-005 SHALL have ports: PC out 32; opcode out 6; address out 26; immediate out 16; rs out 5 (fields that feed the PC address generator and the register file).
REQ-006 SHALL have ports: PC4 in 32; branchAddress in 32; jumpAddress in 32 (candidate next-PC values from the generator).
REQ-007 SHALL have ports: pc_src in 2 (00 PC4, 01 branch, 10 jump, 11 hold); branch_taken in 1; update in 1 (commit request from control).
REQ-008 SHALL have ports: instr_valid out 1; busy out 1; timeout out 1; fault out 1.

Function
REQ-009 SHALL implement FSM states FETCH, DECODE, WAIT_UPD.
REQ-010 FETCH: imem_req=1, imem_addr=PC; on imem_ack SHALL latch imem_rdata into the instruction register (IR) and go to DECODE on the next edge.
REQ-011 DECODE SHALL last exactly one cycle, with instr_valid=1, then go to WAIT_UPD.
REQ-012 opcode=IR[31:26], rs=IR[25:21], immediate=IR[15:0], address=IR[25:0]; all SHALL be stable from DECODE until the next IR load.
REQ-013 WAIT_UPD: on update=1 SHALL load PC per pc_src on that edge and go to FETCH; pc_src=11 keeps PC and still refetches.
REQ-014 pc_src=01 SHALL load branchAddress only when branch_taken=1, otherwise PC4.
REQ-015 update SHALL be ignored in FETCH and DECODE; imem_ack SHALL be ignored outside FETCH.
REQ-016 busy SHALL be 1 in FETCH and DECODE, and 0 in WAIT_UPD.
REQ-017 An ack-wait counter SHALL count FETCH cycles without ack; on reaching ACK_TIMEOUT it SHALL pulse timeout for 1 cycle, clear, and keep imem_req asserted (retry).
REQ-018 An ack in the same cycle the counter reaches ACK_TIMEOUT SHALL take priority: IR is loaded and no timeout pulse occurs.
REQ-019 PC arithmetic SHALL be 32-bit; wrap-around from 32'hFFFFFFFC is whatever PC4 supplies, with no checking.

Reset
REQ-020 On reset=1 at an edge: state=FETCH, PC=RESET_PC, IR=0, counter=0, instr_valid=0, timeout=0, fault=0.
REQ-021 Reset mid-fetch SHALL abandon the outstanding request; any ack in the reset cycle SHALL be discarded.
REQ-022 imem_req SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-023 With macro PC_ALIGN_CHECK_EN defined: a load where target[1:0]!=0 SHALL NOT update PC, SHALL set sticky fault=1 (cleared only by reset), and the FSM SHALL stay in WAIT_UPD.
REQ-024 Without PC_ALIGN_CHECK_EN: any target SHALL load unchecked and fault SHALL be tied 0.

Structure
REQ-025 A shared package SHALL hold the pc_src encodings, the FSM state enum, and the IR field bit positions.
REQ-026 The ack-wait counter SHALL be the sub-module pc_fetch_timer (inputs: enable, clear; output: expired).

Verification
REQ-027 Reset with RESET_PC=0: imem_req=1 and imem_addr=0 in the first post-reset cycle.
REQ-028 imem_rdata=32'h08000003 acked: next cycle instr_valid=1, opcode=6'h02, address=26'h3; then update=1, pc_src=10, jumpAddress=32'hC -> PC=32'hC and imem_addr=32'hC.
REQ-029 pc_src=01, branch_taken=0, PC4=4, branchAddress=32'h40, update=1 -> PC=4; repeated with branch_taken=1 -> PC=32'h40.
REQ-030 No ack for 16 FETCH cycles -> timeout pulses for 1 cycle and imem_req stays 1; a later ack proceeds to DECODE normally.
REQ-031 update=1 held during FETCH -> PC unchanged; reset asserted mid-FETCH together with ack -> IR=0 and PC=RESET_PC.
REQ-032 With PC_ALIGN_CHECK_EN, jumpAddress=32'h6 and update=1 -> fault=1, PC unchanged, state WAIT_UPD; without the macro -> PC=32'h6.
